// File: rtl/layer_sequencer.sv
// Sequencing controller for one fully-connected layer: forwards host configuration words,
// streams numWeight samples per inference, gathers per-neuron results and hands them out.
module layer_sequencer #(
    parameter int NN        = 1,
    parameter int numWeight = 5,
    parameter int dataWidth = 16,
    parameter int wWidth    = 16,
    parameter int layerNum  = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    cfg_is_bias,
    input  logic [31:0]             cfg_neuron,
    input  logic [wWidth-1:0]       cfg_data,

    output logic                    weightValid,
    output logic                    biasValid,
    output logic [wWidth-1:0]       weightValue,
    output logic [wWidth-1:0]       biasValue,
    output logic [31:0]             config_layer_num,
    output logic [31:0]             config_neuron_num,

    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [dataWidth-1:0]    s_data,

    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,

    input  logic [NN-1:0]           o_valid,
    input  logic [NN*dataWidth-1:0] x_out,

    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [NN*dataWidth-1:0] m_data,

    output logic                    busy,
    output logic                    err_timeout
);

    localparam int CntWidth = (numWeight > 1) ? $clog2(numWeight) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StWait, StOutput} state_t;

    state_t                    state_q;
    logic [CntWidth-1:0]       cnt_q;
    logic [NN-1:0]             done_q;
    logic [NN-1:0]             done_next;
    logic [31:0]               wait_cnt_q;
    logic [NN*dataWidth-1:0]   result_q;
    logic                      cfg_accept;
    logic                      s_accept;

    // Config has priority over samples in IDLE, so s_ready drops while cfg_valid is high there.
    assign cfg_ready  = (state_q == StIdle);
    assign s_ready    = (state_q == StStream) || ((state_q == StIdle) && !cfg_valid);
    assign cfg_accept = cfg_valid && cfg_ready;
    assign s_accept   = s_valid && s_ready;
    assign done_next  = done_q | o_valid;

    assign config_layer_num = 32'(layerNum);
    assign busy             = (state_q != StIdle);
    assign m_data           = result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            done_q            <= '0;
            wait_cnt_q        <= '0;
            result_q          <= '0;
            weightValid       <= 1'b0;
            biasValid         <= 1'b0;
            weightValue       <= '0;
            biasValue         <= '0;
            config_neuron_num <= '0;
            x_valid           <= 1'b0;
            x_in              <= '0;
            m_valid           <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            x_valid     <= 1'b0;

            if (cfg_accept) begin
                config_neuron_num <= cfg_neuron;
                if (cfg_is_bias) begin
                    biasValid <= 1'b1;
                    biasValue <= cfg_data;
                end else begin
                    weightValid <= 1'b1;
                    weightValue <= cfg_data;
                end
            end

            if (s_accept) begin
                x_valid <= 1'b1;
                x_in    <= s_data;
            end

            unique case (state_q)
                StIdle: begin
                    wait_cnt_q <= '0;
                    if (s_accept) begin
                        if (numWeight == 1) begin
                            cnt_q   <= '0;
                            state_q <= StWait;
                        end else begin
                            cnt_q   <= CntWidth'(1);
                            state_q <= StStream;
                        end
                    end
                end
                StStream: begin
                    wait_cnt_q <= '0;
                    if (s_accept) begin
                        if (cnt_q == CntWidth'(numWeight - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StWait;
                        end else begin
                            cnt_q <= cnt_q + CntWidth'(1);
                        end
                    end
                end
                StWait: begin
                    done_q <= done_next;
                    for (int i = 0; i < NN; i++) begin
                        if (o_valid[i]) begin
                            result_q[i*dataWidth +: dataWidth] <= x_out[i*dataWidth +: dataWidth];
                        end
                    end
                    // Completion beats the watchdog when both land on the same cycle.
                    if (&done_next) begin
                        m_valid <= 1'b1;
                        state_q <= StOutput;
                    end else if ((TIMEOUT > 0) && (wait_cnt_q == 32'(TIMEOUT - 1))) begin
                        err_timeout <= 1'b1;
                        done_q      <= '0;
                        state_q     <= StIdle;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                StOutput: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        done_q  <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed scenarios with literal checks, then random traffic,
// all cross-checked every cycle against a transaction-level model of the controller.
module tb_layer_sequencer;

    localparam int NN = 3;
    localparam int NW = 5;
    localparam int DW = 16;
    localparam int WW = 16;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic            cfg_is_bias = 1'b0;
    logic [31:0]     cfg_neuron = '0;
    logic [WW-1:0]   cfg_data = '0;
    logic            weightValid, biasValid;
    logic [WW-1:0]   weightValue, biasValue;
    logic [31:0]     config_layer_num, config_neuron_num;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            x_valid;
    logic [DW-1:0]   x_in;
    logic [NN-1:0]   o_valid = '0;
    logic [NN*DW-1:0] x_out = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [NN*DW-1:0] m_data;
    logic            busy, err_timeout;

    layer_sequencer #(
        .NN(NN), .numWeight(NW), .dataWidth(DW), .wWidth(WW), .layerNum(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_is_bias(cfg_is_bias),
        .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
        .weightValid(weightValid), .biasValid(biasValid),
        .weightValue(weightValue), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .x_valid(x_valid), .x_in(x_in),
        .o_valid(o_valid), .x_out(x_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    localparam int PhIdle = 0, PhStream = 1, PhWait = 2, PhOut = 3;

    int            ph;
    int            taken;
    int            waited;
    logic [NN-1:0] got;
    logic [DW-1:0] res [NN];
    logic          e_wv, e_bv, e_xv, e_mv, e_err;
    logic [WW-1:0] e_wval, e_bval;
    logic [31:0]   e_nn;
    logic [DW-1:0] e_xin;

    task automatic model_reset();
        ph = PhIdle; taken = 0; waited = 0; got = '0;
        for (int i = 0; i < NN; i++) res[i] = '0;
        e_wv = 0; e_bv = 0; e_xv = 0; e_mv = 0; e_err = 0;
        e_wval = '0; e_bval = '0; e_nn = '0; e_xin = '0;
    endtask

    task automatic take_sample();
        e_xv = 1; e_xin = s_data; taken++;
        if (taken == NW) begin
            ph = PhWait; waited = 0; taken = 0;
        end else begin
            ph = PhStream;
        end
    endtask

    task automatic model_step();
        e_wv = 0; e_bv = 0; e_xv = 0;
        case (ph)
            PhIdle: begin
                if (cfg_valid) begin
                    e_nn = cfg_neuron;
                    if (cfg_is_bias) begin e_bv = 1; e_bval = cfg_data; end
                    else begin e_wv = 1; e_wval = cfg_data; end
                end else if (s_valid) begin
                    taken = 0;
                    take_sample();
                end
            end
            PhStream: if (s_valid) take_sample();
            PhWait: begin
                waited++;
                for (int i = 0; i < NN; i++)
                    if (o_valid[i]) begin got[i] = 1; res[i] = x_out[i*DW +: DW]; end
                if (&got) begin
                    ph = PhOut; e_mv = 1;
                end else if (waited == TO) begin
                    e_err = 1; got = '0; ph = PhIdle;
                end
            end
            default: if (m_ready) begin e_mv = 0; got = '0; ph = PhIdle; end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [NN*DW-1:0] e_md;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NN; i++) e_md[i*DW +: DW] = res[i];
            chk("cfg_ready", 64'(cfg_ready), 64'(ph == PhIdle));
            chk("s_ready", 64'(s_ready), 64'((ph == PhStream) || (ph == PhIdle && !cfg_valid)));
            chk("busy", 64'(busy), 64'(ph != PhIdle));
            chk("weightValid", 64'(weightValid), 64'(e_wv));
            chk("biasValid", 64'(biasValid), 64'(e_bv));
            chk("weightValue", 64'(weightValue), 64'(e_wval));
            chk("biasValue", 64'(biasValue), 64'(e_bval));
            chk("neuron_num", 64'(config_neuron_num), 64'(e_nn));
            chk("layer_num", 64'(config_layer_num), 64'd1);
            chk("x_valid", 64'(x_valid), 64'(e_xv));
            chk("x_in", 64'(x_in), 64'(e_xin));
            chk("m_valid", 64'(m_valid), 64'(e_mv));
            chk("err_timeout", 64'(err_timeout), 64'(e_err));
            if (e_mv) chk("m_data", 64'(m_data), 64'(e_md));
        end
    end

    // ---------------- stimulus ----------------
    task automatic stream(input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            s_valid = 1; s_data = base + DW'(k);
            tick();
            chk("lit_x_valid", 64'(x_valid), 64'd1);
            chk("lit_x_in", 64'(x_in), 64'(base + DW'(k)));
        end
        s_valid = 0;
    endtask

    task automatic respond(input int delay, input logic [NN*DW-1:0] vals);
        for (int d = 0; d < delay; d++) tick();
        o_valid = '1; x_out = vals; m_ready = 1;
        tick();
        o_valid = '0;
        chk("lit_resp_mvalid", 64'(m_valid), 64'd1);
        chk("lit_resp_mdata", 64'(m_data), 64'(vals));
        tick();
        chk("lit_resp_idle", 64'(busy), 64'd0);
        m_ready = 0;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1;
        tick();
        chk("lit_rst_busy", 64'(busy), 64'd0);
        chk("lit_rst_mvalid", 64'(m_valid), 64'd0);
        chk("lit_rst_err", 64'(err_timeout), 64'd0);
        chk("lit_rst_layer", 64'(config_layer_num), 64'd1);

        // Configuration words
        cfg_valid = 1; cfg_is_bias = 0; cfg_neuron = 0; cfg_data = 16'h0011;
        tick();
        chk("lit_w1_valid", 64'(weightValid), 64'd1);
        chk("lit_w1_value", 64'(weightValue), 64'h0011);
        cfg_data = 16'h0022;
        tick();
        chk("lit_w2_value", 64'(weightValue), 64'h0022);
        cfg_is_bias = 1; cfg_data = 16'h0005;
        tick();
        chk("lit_b_valid", 64'(biasValid), 64'd1);
        chk("lit_b_wvalid", 64'(weightValid), 64'd0);
        chk("lit_b_value", 64'(biasValue), 64'h0005);
        cfg_valid = 0; cfg_is_bias = 0;
        tick();
        chk("lit_b_pulse", 64'(biasValid), 64'd0);

        // Inference with staggered neuron responses
        stream(16'd1, NW);
        chk("lit_sready_wait", 64'(s_ready), 64'd0);
        for (int c = 1; c <= 7; c++) begin
            x_out = (NN*DW)'({$urandom, $urandom});
            o_valid = '0;
            if (c == 2) begin o_valid[0] = 1; x_out[15:0] = 16'h000A; end
            if (c == 4) begin o_valid[1] = 1; x_out[31:16] = 16'h000C; end
            if (c == 7) begin o_valid[2] = 1; x_out[47:32] = 16'h000B; end
            chk("lit_no_early_mvalid", 64'(m_valid), 64'd0);
            tick();
        end
        o_valid = '0;
        chk("lit_mvalid", 64'(m_valid), 64'd1);
        chk("lit_mdata", 64'(m_data), 64'h0000_000B_000C_000A);
        for (int h = 0; h < 3; h++) begin
            tick();
            chk("lit_mvalid_hold", 64'(m_valid), 64'd1);
        end
        m_ready = 1;
        tick();
        chk("lit_handshake", 64'(m_valid), 64'd0);
        m_ready = 0;

        // Config and sample together in IDLE
        cfg_valid = 1; cfg_data = 16'h0033; cfg_neuron = 2; s_valid = 1; s_data = 16'h0077;
        #1;
        chk("lit_both_sready", 64'(s_ready), 64'd0);
        tick();
        chk("lit_both_cfg", 64'(weightValid), 64'd1);
        chk("lit_both_nosample", 64'(x_valid), 64'd0);
        cfg_valid = 0;
        #1;
        chk("lit_both_sready2", 64'(s_ready), 64'd1);
        tick();
        chk("lit_both_sample", 64'(x_in), 64'h0077);
        stream(16'h0078, NW - 1);
        respond(0, 48'h0003_0002_0001);

        // Watchdog
        stream(16'h0010, NW);
        for (int i = 1; i <= TO; i++) begin
            tick();
            chk("lit_to_err", 64'(err_timeout), 64'(i == TO));
        end
        chk("lit_to_idle", 64'(busy), 64'd0);
        stream(16'h0020, NW);
        respond(2, 48'h1234_5678_9ABC);
        chk("lit_to_sticky", 64'(err_timeout), 64'd1);

        // Reset mid-stream
        stream(16'h0030, 3);
        rst = 0;
        #1;
        chk("lit_mid_busy", 64'(busy), 64'd0);
        chk("lit_mid_xvalid", 64'(x_valid), 64'd0);
        chk("lit_mid_err", 64'(err_timeout), 64'd0);
        chk("lit_mid_wval", 64'(weightValue), 64'd0);
        tick();
        rst = 1;
        tick();
        stream(16'h0040, NW);
        respond(1, 48'h00AA_00BB_1234);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 499) != 0);
            cfg_valid   = ($urandom_range(0, 7) == 0);
            cfg_is_bias = 1'($urandom_range(0, 1));
            cfg_neuron  = $urandom;
            cfg_data    = WW'($urandom);
            s_valid     = ($urandom_range(0, 3) != 0);
            s_data      = DW'($urandom);
            for (int i = 0; i < NN; i++) o_valid[i] = ($urandom_range(0, 5) == 0);
            x_out       = (NN*DW)'({$urandom, $urandom});
            m_ready     = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1; cfg_valid = 0; s_valid = 0; o_valid = '0; m_ready = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequencing controller for one fully-connected layer instance (NN neurons sharing one serial input, numWeight weights each). It accepts weight/bias configuration words from a host port and drives the layer's configuration bus. It streams exactly numWeight input samples per inference into the layer's x_valid/x_in, waits until every neuron has reported o_valid, and presents the NN results as one output word with a valid/ready handshake. It sits between the network-level input FIFO/host loader and the layer instance.

## Interface
- NN, 1, number of neurons in the controlled layer
- numWeight, 5, samples per inference (≥1)
- dataWidth, 16, sample/result width
- wWidth, 16, configuration value width (weight and bias)
- layerNum, 1, value driven on config_layer_num
- TIMEOUT, 0, max WAIT cycles before abort; 0 disables the watchdog

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  host config word valid
- cfg_ready  out  1  config word accepted when cfg_valid & cfg_ready
- cfg_is_bias  in  1  1 = bias word, 0 = weight word
- cfg_neuron  in  32  target neuron index
- cfg_data  in  wWidth  weight/bias value
- weightValid, biasValid  out  1 each  to layer
- weightValue, biasValue  out  wWidth each  to layer
- config_layer_num, config_neuron_num  out  32 each  to layer
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid & s_ready
- s_data  in  dataWidth  input sample
- x_valid  out  1  to layer
- x_in  out  dataWidth  to layer
- o_valid  in  NN  per-neuron result valid from layer
- x_out  in  NN*dataWidth  neuron results, neuron i at [i*dataWidth +: dataWidth]
- m_valid  out  1  result word valid
- m_ready  in  1  result consumer ready
- m_data  out  NN*dataWidth  captured results
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky watchdog flag, cleared only by reset

## Operation
- States: IDLE, STREAM, WAIT, OUTPUT.
- IDLE: cfg_ready=1, s_ready=1. If cfg_valid, accept config (priority over samples; s_ready is 0 that cycle). Otherwise, if s_valid, accept the sample, set cnt=1, and go to STREAM (to WAIT if numWeight==1).
- Config accept: next cycle weightValid (cfg_is_bias=0) or biasValid (=1) pulses for exactly 1 cycle. The matching value bus carries cfg_data, and config_neuron_num=cfg_neuron. Value and neuron registers hold until the next accept. config_layer_num is constant layerNum.
- STREAM: cfg_ready=0, s_ready=1. Each accept increments cnt. The accept with cnt==numWeight-1 goes to WAIT. Sample count wraps to 0 at the transition.
- Every accepted sample appears on x_in with x_valid=1 exactly 1 cycle after acceptance. x_valid is otherwise 0. x_in holds its last value.
- WAIT: s_ready=0, cfg_ready=0.
  - Sticky mask done |= o_valid each cycle.
  - For each bit set this cycle, result slice i <= x_out slice i.
  - A repeated o_valid on an already-done bit overwrites the slice (last wins).
  - When (done | o_valid) is all ones, go to OUTPUT.
  - o_valid seen in any other state is ignored; no capture.
- Watchdog (TIMEOUT>0): a WAIT cycle counter saturates. Reaching TIMEOUT sets err_timeout, clears done, and goes to IDLE without asserting m_valid.
- OUTPUT: m_valid=1, m_data=result (stable while m_valid). On m_ready, clear done and go to IDLE. s_ready=0 and cfg_ready=0 throughout.
- Reset mid-operation clears all state. The layer's own accumulators are not resynchronised by this block; the system resets both together.

## Timing
- Reset values: state IDLE, all valid pulses 0, m_valid 0, busy 0, err_timeout 0, all data/value/num registers 0, config_layer_num = layerNum, cnt 0, done 0.
- cfg_ready/s_ready are combinational from state only (no dependence on same-cycle valid, except the s_ready gating by cfg_valid in IDLE).
- Minimum inference: numWeight accept cycles + neuron latency + 1 capture cycle + ≥1 OUTPUT cycle.
- m_valid rises the cycle after the last neuron's o_valid is seen. The m_ready handshake and return to IDLE complete in that same cycle if m_ready=1.
- Back-to-back inferences: a sample may be accepted in the first IDLE cycle after OUTPUT.

## Test plan
- Reset, then config: weight words 0x0011, 0x0022 to neuron 0, then bias 0x0005 → weightValid pulses twice with the values in order, biasValid pulses once with 0x0005, config_neuron_num=0, config_layer_num=1.
- NN=1, numWeight=5, samples 1..5 with continuous s_valid; model neuron asserts o_valid 3 cycles after the 5th x_valid with 0x1234 → x_valid high 5 cycles, s_ready low from the 6th cycle, m_data=0x1234, m_valid held until m_ready.
- NN=3, o_valid bits arriving at cycles 2, 7, 4 of WAIT with 0xA, 0xB, 0xC → m_valid only after the cycle-7 arrival, m_data = {0xB? no: slice2=0xB, slice1=0xC, slice0=0xA}.
- cfg_valid and s_valid both high in IDLE → config accepted, no sample accepted that cycle; sample accepted the next cycle.
- TIMEOUT=10, neuron never responds → err_timeout=1 after 10 WAIT cycles, state IDLE, m_valid never asserted; the next inference completes normally.
- rst low during STREAM after 3 samples → all outputs at reset values; a full 5-sample inference afterwards produces a correct result.
